ahb_sram_slave: RTL

AHB-Lite responder that terminates transfers from the AHB master into a word-organised on-chip SRAM, with configurable wait states and two-cycle ERROR responses. It drives the slave-side signals of the AHB bus bundle (`hreadyout`, `hresp`, `hrdata`) and consumes the master-side ones. It serves as the default memory target in the VIP environment and as the DUT for master-agent bring-up.

---
 rtl/ahb_pkg.sv | 55 +++++
 rtl/ahb_sram_slave_mem.sv | 29 ++
 rtl/ahb_sram_slave.sv | 118 +++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the SRAM responder.
// Also provides the byte-lane decode used by the write port.
package ahb_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TRANS_W = 2;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 3;
  localparam int unsigned STRB_W  = DATA_W / 8;
  localparam int unsigned WS_W    = 4;

  typedef enum logic [TRANS_W-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [SIZE_W-1:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } slave_state_e;

  // Attributes of the accepted transfer held through its data phase.
  typedef struct packed {
    logic              write;
    logic [SIZE_W-1:0] size;
    logic [1:0]        lane;
  } xfer_t;

  // Little-endian byte enables for a legal transfer.
  function automatic logic [STRB_W-1:0] byte_lanes(input logic [SIZE_W-1:0] size,
                                                   input logic [1:0] lane);
    logic [STRB_W-1:0] be;
    case (size)
      HSIZE_BYTE: be = STRB_W'(4'b0001 << lane);
      HSIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_mem.sv
// Word-organised SRAM: byte-enable synchronous write, asynchronous read.
// Contents are intentionally left unreset.
module ahb_sram_slave_mem
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [STRB_W-1:0] be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < int'(STRB_W); b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder into on-chip SRAM with configurable wait states
// and two-cycle ERROR responses; address/data phases pipeline.
module ahb_sram_slave
  import ahb_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic               hclk,
  input  logic               hresetn,
  input  logic               hsel,
  input  logic [ADDR_W-1:0]  haddr,
  input  logic [TRANS_W-1:0] htrans,
  input  logic               hwrite,
  input  logic [SIZE_W-1:0]  hsize,
  input  logic [BURST_W-1:0] hburst,
  input  logic [DATA_W-1:0]  hwdata,
  input  logic               hready,
  output logic               hreadyout,
  output logic               hresp,
  output logic [DATA_W-1:0]  hrdata
);

  localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  slave_state_e      state_q, state_n;
  logic [WS_W-1:0]   cnt_q, cnt_n;
  logic              dp_q, dp_n;
  xfer_t             xfer_q;
  logic [IDX_W-1:0]  idx_q;
  logic              accept_c, illegal_c, we_c;
  logic [STRB_W-1:0] be_c;
  logic [DATA_W-1:0] mem_rdata;

  // Bursts are handled beat by beat; sequential vs non-sequential is irrelevant.
  logic unused_ok;
  assign unused_ok = ^{hburst, htrans[0]};

  always_comb begin
    illegal_c = 1'b0;
    if ({2'b00, haddr[ADDR_W-1:2]} >= 32'(MEM_DEPTH)) illegal_c = 1'b1;
    if (hsize > SIZE_W'(HSIZE_WORD))                  illegal_c = 1'b1;
    if (hsize == SIZE_W'(HSIZE_HALF) && haddr[0])     illegal_c = 1'b1;
    if (hsize == SIZE_W'(HSIZE_WORD) && haddr[1:0] != 2'b00) illegal_c = 1'b1;
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dp_q    <= 1'b0;
      xfer_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      dp_q    <= dp_n;
      if (accept_c) begin
        xfer_q <= '{write: hwrite, size: hsize, lane: haddr[1:0]};
        idx_q  <= haddr[IDX_W+1:2];
      end
    end
  end

  // dp_q marks a legal transfer whose data phase is in progress.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    dp_n     = dp_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_ERR2: begin
        state_n = ST_IDLE;
        dp_n    = 1'b0;
        if (hsel && hready && htrans[1]) begin
          accept_c = 1'b1;
          if (illegal_c) begin
            state_n = ST_ERR1;
          end else begin
            dp_n = 1'b1;
            if (WAIT_STATES != 0) begin
              state_n = ST_WAIT;
              cnt_n   = WS_W'(WAIT_STATES);
            end
          end
        end
      end
      ST_WAIT: begin
        cnt_n = (cnt_q != '0) ? cnt_q - WS_W'(1) : '0;
        if (cnt_q <= WS_W'(1)) state_n = ST_IDLE;
      end
      ST_ERR1: state_n = ST_ERR2;
      default: state_n = ST_IDLE;
    endcase
  end

  assign we_c = (state_q == ST_IDLE) && dp_q && xfer_q.write;
  assign be_c = byte_lanes(xfer_q.size, xfer_q.lane);

  ahb_sram_slave_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .IDX_W     (IDX_W)
  ) u_mem (
    .clk   (hclk),
    .we    (we_c),
    .be    (be_c),
    .idx   (idx_q),
    .wdata (hwdata),
    .rdata (mem_rdata)
  );

  // Outputs decode directly from registered state; read data is combinational
  // so a read right behind a write to the same word sees the new value.
  assign hreadyout = !(state_q == ST_WAIT || state_q == ST_ERR1);
  assign hresp     = (state_q == ST_ERR1 || state_q == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign hrdata    = (state_q == ST_IDLE && dp_q && !xfer_q.write) ? mem_rdata : '0;

endmodule
